// File: rtl/pcounter_pkg.sv
// Shared op encodings for the program counter with return-address stack.
package pcounter_pkg;
    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_NOP    = 3'd0,
        OP_INC    = 3'd1,
        OP_JUMP   = 3'd2,
        OP_BRANCH = 3'd3,
        OP_CALL   = 3'd4,
        OP_RET    = 3'd5
    } op_e;
endpackage

// File: rtl/ret_stack.sv
// LIFO of return addresses; only the occupancy count is reset, contents are don't-care.
module ret_stack #(
    parameter int DATA_W = 4,
    parameter int DEPTH  = 4,
    localparam int SPW   = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic [SPW-1:0]    sp,
    output logic              full,
    output logic              empty
);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem [2**IW];
    logic [SPW-1:0]    sp_m1;
    logic              do_push;
    logic              do_pop;

    assign full    = (sp == SPW'(DEPTH));
    assign empty   = (sp == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign sp_m1   = sp - 1'b1;
    assign dout    = empty ? '0 : mem[sp_m1[IW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       sp <= '0;
        else if (do_push) sp <= sp + 1'b1;
        else if (do_pop)  sp <= sp_m1;
    end

    // Gated by rst_n so a push coinciding with reset leaves no trace.
    always_ff @(posedge clk) begin
        if (rst_n && do_push) mem[sp[IW-1:0]] <= din;
    end
endmodule

// File: rtl/pcounter_stack.sv
// Program counter with inc/jump/relative branch and call/return via ret_stack.
module pcounter_stack
    import pcounter_pkg::*;
#(
    parameter int          ADDRESS_WIDTH = 4,
    parameter int          STACK_DEPTH   = 4,
    parameter int unsigned RESET_ADDR    = 0,
    localparam int         SPW           = $clog2(STACK_DEPTH + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [OP_W-1:0]          op,
    input  logic                     out_enable,
    input  logic [ADDRESS_WIDTH-1:0] bus_in,
    input  logic                     clr_err,
    output logic [ADDRESS_WIDTH-1:0] bus_out,
    output logic [ADDRESS_WIDTH-1:0] pc,
    output logic [SPW-1:0]           sp,
    output logic                     stack_full,
    output logic                     stack_empty,
    output logic                     err_overflow,
    output logic                     err_underflow
);
    localparam int AW = ADDRESS_WIDTH;

    logic [AW-1:0] pc_inc;
    logic [AW-1:0] pc_next;
    logic [AW-1:0] ret_addr;
    logic          push;
    logic          pop;
    logic          set_ovf;
    logic          set_unf;

    assign pc_inc  = pc + 1'b1;
    assign push    = (op == OP_CALL) && !stack_full;
    assign pop     = (op == OP_RET) && !stack_empty;
    assign set_ovf = (op == OP_CALL) && stack_full;
    assign set_unf = (op == OP_RET) && stack_empty;
    assign bus_out = out_enable ? pc : '0;

    ret_stack #(
        .DATA_W (AW),
        .DEPTH  (STACK_DEPTH)
    ) u_stack (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   (pc_inc),
        .dout  (ret_addr),
        .sp    (sp),
        .full  (stack_full),
        .empty (stack_empty)
    );

    always_comb begin
        pc_next = pc;
        case (op)
            OP_INC:    pc_next = pc_inc;
            OP_JUMP:   pc_next = bus_in;
            // Offset already spans the full PC width, so the modular add is the signed add.
            OP_BRANCH: pc_next = pc + bus_in;
            OP_CALL:   if (push) pc_next = bus_in;
            OP_RET:    if (pop)  pc_next = ret_addr;
            default:   pc_next = pc;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc            <= AW'(RESET_ADDR);
            err_overflow  <= 1'b0;
            err_underflow <= 1'b0;
        end else begin
            pc            <= pc_next;
            err_overflow  <= set_ovf | (err_overflow & ~clr_err);
            err_underflow <= set_unf | (err_underflow & ~clr_err);
        end
    end
endmodule

// File: tb/tb_pcounter_stack.sv
// Randomised + directed bench for pcounter_stack against a queue-based reference model.
module tb_pcounter_stack;
    import pcounter_pkg::*;

    localparam int AW    = 4;
    localparam int DEPTH = 4;
    localparam int RA    = 0;
    localparam int SPW   = $clog2(DEPTH + 1);
    localparam int MOD   = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [2:0]    op;
    logic          out_enable;
    logic [AW-1:0] bus_in;
    logic          clr_err;
    logic [AW-1:0] bus_out;
    logic [AW-1:0] pc;
    logic [SPW-1:0] sp;
    logic          stack_full, stack_empty, err_overflow, err_underflow;

    int vectors = 0;
    int miscompares = 0;

    int pc_m;
    int stk[$];
    bit ovf_m, unf_m;

    pcounter_stack #(
        .ADDRESS_WIDTH (AW),
        .STACK_DEPTH   (DEPTH),
        .RESET_ADDR    (RA)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .op            (op),
        .out_enable    (out_enable),
        .bus_in        (bus_in),
        .clr_err       (clr_err),
        .bus_out       (bus_out),
        .pc            (pc),
        .sp            (sp),
        .stack_full    (stack_full),
        .stack_empty   (stack_empty),
        .err_overflow  (err_overflow),
        .err_underflow (err_underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        pc_m = RA % MOD;
        stk.delete();
        ovf_m = 0;
        unf_m = 0;
    endtask

    task automatic model_step(input int o, input int b, input bit c);
        bit so, su;
        int off;
        so = 0;
        su = 0;
        case (o)
            1: pc_m = (pc_m + 1) % MOD;
            2: pc_m = b;
            3: begin
                off  = (b >= MOD / 2) ? b - MOD : b;
                pc_m = ((pc_m + off) % MOD + MOD) % MOD;
            end
            4: if (stk.size() == DEPTH) so = 1;
               else begin
                   stk.push_back((pc_m + 1) % MOD);
                   pc_m = b;
               end
            5: if (stk.size() == 0) su = 1;
               else pc_m = stk.pop_back();
            default: ;
        endcase
        ovf_m = so || (ovf_m && !c);
        unf_m = su || (unf_m && !c);
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".pc"}, 32'(pc), 32'(pc_m));
        chk({tag, ".sp"}, 32'(sp), 32'(stk.size()));
        chk({tag, ".full"}, 32'(stack_full), 32'(stk.size() == DEPTH));
        chk({tag, ".empty"}, 32'(stack_empty), 32'(stk.size() == 0));
        chk({tag, ".ovf"}, 32'(err_overflow), 32'(ovf_m));
        chk({tag, ".unf"}, 32'(err_underflow), 32'(unf_m));
        chk({tag, ".bus_out"}, 32'(bus_out), out_enable ? 32'(pc_m) : 32'd0);
    endtask

    task automatic step(input string tag, input int o, input int b, input bit oe, input bit c);
        @(negedge clk);
        op         = 3'(o);
        bus_in     = AW'(b);
        out_enable = oe;
        clr_err    = c;
        @(posedge clk);
        model_step(o, b, c);
        #1;
        check_all(tag);
    endtask

    initial begin
        rst_n      = 1'b0;
        op         = 3'd0;
        out_enable = 1'b0;
        bus_in     = '0;
        clr_err    = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("rst");
        chk("rst.pc_const", 32'(pc), RA);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 17; i++) step("inc", 1, 0, 1'($urandom), 0);
        chk("inc_wrap", 32'(pc), 1);

        step("jmp", 2, 5, 1, 0);
        step("br_neg", 3, 14, 1, 0);
        chk("br_neg_const", 32'(pc), 3);
        step("jmp", 2, 14, 0, 0);
        step("br_wrap", 3, 3, 1, 0);
        chk("br_wrap_const", 32'(pc), 1);

        step("jmp", 2, 2, 0, 0);
        step("call", 4, 9, 1, 0);
        chk("call_pc", 32'(pc), 9);
        step("inc", 1, 0, 0, 0);
        step("ret", 5, 0, 1, 0);
        chk("ret_pc", 32'(pc), 3);
        chk("ret_empty", 32'(stack_empty), 1);

        for (int i = 0; i < 5; i++) step("call5", 4, 3 * i + 1, 1, 0);
        chk("ovf_sp", 32'(sp), DEPTH);
        chk("ovf_flag", 32'(err_overflow), 1);
        for (int i = 0; i < 5; i++) step("ret5", 5, 0, 1, 0);
        chk("unf_flag", 32'(err_underflow), 1);
        step("clr", 0, 0, 0, 1);
        chk("clr_ovf", 32'(err_overflow), 0);
        chk("clr_unf", 32'(err_underflow), 0);
        step("clr_vs_set", 5, 0, 0, 1);
        chk("set_wins", 32'(err_underflow), 1);

        step("rsv7", 7, 11, 1, 0);
        step("rsv6", 6, 11, 1, 0);
        for (int i = 0; i < 3; i++) step("nop", 0, 13, 1, 0);

        step("pre_rst", 4, 5, 0, 0);
        step("pre_rst", 4, 10, 0, 0);
        @(negedge clk);
        op = 3'(OP_CALL);
        bus_in = 4'd7;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("arst.pc", 32'(pc), RA);
        chk("arst.sp", 32'(sp), 0);
        chk("arst.empty", 32'(stack_empty), 1);
        @(negedge clk);
        op = 3'd0;
        rst_n = 1'b1;
        #1;
        check_all("arst");

        for (int i = 0; i < 1500; i++) begin
            int r, o;
            r = int'($urandom_range(0, 11));
            o = (r < 3) ? 4 : (r < 6) ? 5 : (r < 8) ? 1 : (r - 6) % 8;
            step("rand", o, int'($urandom_range(0, MOD - 1)), 1'($urandom), ($urandom_range(0, 7) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
